pipelined_port_ram: RTL and testbench

Parametrised single-port synchronous RAM: next generation of the team's single-port memory. Adds a valid/ready request interface, per-byte write enables, a registered read path of configurable latency, and an optional post-reset clear engine. It serves as the local data/frame store behind the core's load/store unit and video fetch logic.

---
 rtl/pipelined_port_ram_pkg.sv | 17 +
 rtl/ram_read_pipe.sv | 52 +++++
 rtl/pipelined_port_ram.sv | 126 ++++++++++++
 tb/tb_pipelined_port_ram.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipelined_port_ram_pkg.sv
// Shared types for pipelined_port_ram: control FSM encoding, read latency range, lane helper.
// Pure declarations, no logic.
package pipelined_port_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

  function automatic int lane_count(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Read-data delay line: STAGES registers of data plus valid, zero stages is a wire.
// Latency STAGES cycles; no backpressure, data holds its last value while valid is low.
module ram_read_pipe #(
  parameter int STAGES = 1,
  parameter int WIDTH  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_clk;
      assign unused_clk = clock ^ reset_n;
      assign out_vld    = in_vld;
      assign out_dat    = in_dat;
    end else begin : g_stages
      logic [STAGES-1:0]            vld_q, vld_d;
      logic [STAGES-1:0][WIDTH-1:0] dat_q, dat_d;

      // Data only advances behind a valid bit so the output holds between responses.
      always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = in_vld;
        if (in_vld) dat_d[0] = in_dat;
        for (int i = 1; i < STAGES; i++) begin
          vld_d[i] = vld_q[i-1];
          if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          vld_q <= '0;
          dat_q <= '0;
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
        end
      end

      assign out_vld = vld_q[STAGES-1];
      assign out_dat = dat_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/pipelined_port_ram.sv
// Single-port RAM with byte-lane writes and a READ_LATENCY-deep registered read path.
// Latency READ_LATENCY edges for reads; req_ready low only while the PIPELINED_PORT_RAM_CLEAR_EN zeroing walk runs.
module pipelined_port_ram
  import pipelined_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_SPACE   = 16,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic                                    req_wren,
  input  logic [ADDR_SPACE-1:0]                   req_address,
  input  logic [DATA_WIDTH-1:0]                   req_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]        req_byteen,
  output logic                                    rsp_valid,
  output logic [DATA_WIDTH-1:0]                   rsp_data,
  output logic                                    busy
);

  localparam int NB    = lane_count(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = 1 << ADDR_SPACE;
  localparam int RL    = (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
                         (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY;

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic                  accept;
  logic                  clr_wr;
  logic [ADDR_SPACE-1:0] clr_addr;

  assign accept = req_valid && req_ready;

`ifdef PIPELINED_PORT_RAM_CLEAR_EN
  state_e                state_q, state_d;
  logic [ADDR_SPACE-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_READY);
    busy      = (state_q == ST_CLEAR);
    clr_wr    = (state_q == ST_CLEAR);
  end

  assign clr_addr = clr_cnt_q;
`else
  logic rdy_q, rdy_d;

  assign rdy_d = 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rdy_q <= 1'b0;
    else          rdy_q <= rdy_d;
  end

  assign req_ready = rdy_q;
  assign busy      = 1'b0;
  assign clr_wr    = 1'b0;
  assign clr_addr  = '0;
`endif

  // Array has no reset: contents survive reset unless the clear walk runs.
  always_ff @(posedge clock) begin
    if (clr_wr) begin
      ram[clr_addr] <= '0;
    end else if (accept && req_wren) begin
      for (int i = 0; i < NB; i++) begin
        if (req_byteen[i]) ram[req_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= req_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic                  rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] rd_dat_q, rd_dat_d;

  always_comb begin
    rd_vld_d = accept && !req_wren;
    rd_dat_d = rd_vld_d ? ram[req_address] : rd_dat_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      rd_vld_q <= rd_vld_d;
      rd_dat_q <= rd_dat_d;
    end
  end

  ram_read_pipe #(
    .STAGES (RL - 1),
    .WIDTH  (DATA_WIDTH)
  ) u_read_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .in_vld  (rd_vld_q),
    .in_dat  (rd_dat_q),
    .out_vld (rsp_valid),
    .out_dat (rsp_data)
  );

endmodule

// File: tb/tb_pipelined_port_ram.sv
// Bench: three RAMs (read latency 1, 2, 4; 16 words) driven in lockstep, checked every cycle
// against an array/queue model of the memory, ready/busy timing and response schedule.
module tb_pipelined_port_ram;

  localparam int DEPTH = 16;
`ifdef PIPELINED_PORT_RAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wren = 1'b0;
  logic [3:0]  req_address = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_byteen = '0;
  logic [2:0]        ready_w, busy_w, vld_w;
  logic [2:0][15:0]  dat_w;

  always #5 clock = ~clock;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      pipelined_port_ram #(
        .DATA_WIDTH(16), .ADDR_SPACE(4), .BYTE_WIDTH(8),
        .READ_LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 4))
      ) u_dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(ready_w[g]),
        .req_wren(req_wren), .req_address(req_address), .req_data(req_data),
        .req_byteen(req_byteen), .rsp_valid(vld_w[g]), .rsp_data(dat_w[g]), .busy(busy_w[g])
      );
    end
  endgenerate

  typedef struct {
    bit          w;
    logic [3:0]  a;
    logic [15:0] d;
    logic [1:0]  be;
    logic [15:0] exp_d;
  } vec_t;

  logic [15:0] mmem [DEPTH];
  int          cyc = 0;
  int          edges = 0;
  bit          pend_vld [3][8];
  logic [15:0] pend_dat [3][8];
  logic [15:0] last_dat [3];
  int          n_cmp = 0;
  int          n_fail = 0;
  vec_t        tbl [19];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  function automatic vec_t mk(input bit w, input logic [3:0] a, input logic [15:0] d,
                              input logic [1:0] be, input logic [15:0] e);
    vec_t r;
    r.w = w; r.a = a; r.d = d; r.be = be; r.exp_d = e;
    return r;
  endfunction

  function automatic bit exp_ready();
    if (!reset_n) return 1'b0;
    return CLR ? (edges >= DEPTH) : (edges >= 1);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp_v);
    end
  endtask

  task automatic check_outputs();
    bit eb;
    int idx;
    eb  = reset_n ? (CLR && edges < DEPTH) : CLR;
    idx = cyc % 8;
    for (int k = 0; k < 3; k++) begin
      bit ev;
      ev = pend_vld[k][idx];
      if (ev) last_dat[k] = pend_dat[k][idx];
      pend_vld[k][idx] = 1'b0;
      cmp($sformatf("req_ready_L%0d", lat(k)), ready_w[k], exp_ready());
      cmp($sformatf("busy_L%0d", lat(k)), busy_w[k], eb);
      cmp($sformatf("rsp_valid_L%0d", lat(k)), vld_w[k], ev);
      cmp($sformatf("rsp_data_L%0d", lat(k)), dat_w[k], last_dat[k]);
    end
  endtask

  // One clock: drive, check the cycle's outputs, then advance the model at the edge.
  task automatic step(input bit v, input bit w, input logic [3:0] a, input logic [15:0] d,
                      input logic [1:0] be, input bit use_exp, input logic [15:0] exp_d);
    bit er;
    req_valid = v; req_wren = w; req_address = a; req_data = d; req_byteen = be;
    @(negedge clock);
    check_outputs();
    er = exp_ready();
    @(posedge clock);
    cyc++;
    if (reset_n) begin
      if (v && er) begin
        if (w) begin
          if (be[0]) mmem[a][7:0]  = d[7:0];
          if (be[1]) mmem[a][15:8] = d[15:8];
        end else begin
          for (int k = 0; k < 3; k++) begin
            int due;
            due = (cyc + lat(k) - 1) % 8;
            pend_vld[k][due] = 1'b1;
            pend_dat[k][due] = use_exp ? exp_d : mmem[a];
          end
        end
      end
      if (edges < 100000) edges++;
      if (CLR && edges == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 16'h0);
  endtask

  task automatic apply_reset(input int hold);
    reset_n = 1'b0;
    edges   = 0;
    for (int k = 0; k < 3; k++) begin
      last_dat[k] = '0;
      for (int s = 0; s < 8; s++) pend_vld[k][s] = 1'b0;
    end
    idle(hold);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    #1;
    apply_reset(2);
    idle(DEPTH);

`ifdef PIPELINED_PORT_RAM_CLEAR_EN
    for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b0, 4'(a), 16'h0, 2'b00, 1'b1, 16'h0000);
`endif
    for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b1, 4'(a), 16'(a * 16'h0101), 2'b11, 1'b0, 16'h0);

    for (int a = 0; a < 8; a++) tbl[a] = mk(1'b0, 4'(a), 16'h0, 2'b00, 16'(a * 16'h0101));
    tbl[8]  = mk(1'b1, 4'h3, 16'hBEEF, 2'b11, 16'h0);
    tbl[9]  = mk(1'b1, 4'h3, 16'h12AB, 2'b10, 16'h0);
    tbl[10] = mk(1'b0, 4'h3, 16'h0,    2'b00, 16'h12EF);
    tbl[11] = mk(1'b1, 4'h5, 16'hA5A5, 2'b11, 16'h0);
    tbl[12] = mk(1'b0, 4'h5, 16'h0,    2'b00, 16'hA5A5);
    tbl[13] = mk(1'b1, 4'h6, 16'h1234, 2'b11, 16'h0);
    tbl[14] = mk(1'b1, 4'h6, 16'hFFFF, 2'b00, 16'h0);
    tbl[15] = mk(1'b0, 4'h6, 16'h0,    2'b00, 16'h1234);
    tbl[16] = mk(1'b1, 4'h7, 16'h5678, 2'b01, 16'h0);
    tbl[17] = mk(1'b0, 4'h7, 16'h0,    2'b00, 16'h0778);
    tbl[18] = mk(1'b0, 4'h3, 16'h0,    2'b00, 16'h12EF);
    foreach (tbl[i]) step(1'b1, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, !tbl[i].w, tbl[i].exp_d);
    idle(6);

    // Two reads in flight when reset hits: none of them may respond.
    step(1'b1, 1'b0, 4'h1, 16'h0, 2'b00, 1'b0, 16'h0);
    step(1'b1, 1'b0, 4'h2, 16'h0, 2'b00, 1'b0, 16'h0);
    apply_reset(2);
    idle(6);
    // Reset again partway through the clear walk; it must restart and run its full length.
    apply_reset(2);
    idle(DEPTH + 2);
`ifdef PIPELINED_PORT_RAM_CLEAR_EN
    step(1'b1, 1'b0, 4'h3, 16'h0, 2'b00, 1'b1, 16'h0000);
`else
    step(1'b1, 1'b0, 4'h3, 16'h0, 2'b00, 1'b1, 16'h12EF);
`endif
    idle(5);

    repeat (400) begin
      step(($urandom % 4) != 0, $urandom % 2 == 1, 4'($urandom % 16), 16'($urandom),
           2'($urandom % 4), 1'b0, 16'h0);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
